// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage: alignment checks, lane
// steering, bus handshake FSM, load extension and LL/SC link tracking.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   MemRead..LLSC       access control bits from EX/MEM
//   ALUResult           effective address
//   ReadData2           store data
//   Flush               pipeline flush from CP0
//   dmem_*              data-memory request/response bus
//   MemReadData         extended load data or SC result
//   MemStall            stall request for IF..EX/MEM
//   ExcAdEL/ExcAdES     address-error exceptions, BadVAddr holds address
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemHalf,
    input  logic        MemByte,
    input  logic        MemSignExtend,
    input  logic        LLSC,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    input  logic        Flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] MemReadData,
    output logic        MemStall,
    output logic        ExcAdEL,
    output logic        ExcAdES,
    output logic [31:0] BadVAddr
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        DRAIN
    } state_t;

    state_t      state;
    logic        ll_bit;
    logic [31:0] rdata_q;
    logic [1:0]  lo_q;
    logic        rd_q;
    logic        half_q;
    logic        byte_q;
    logic        sext_q;
    logic        ll_q;
    logic        sc_q;

    logic        rw;
    logic        is_word;
    logic        aligned;
    logic        misaligned;
    logic        sc_fail;
    logic        access;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    // LL and SC are always word accesses
    always_comb begin
        rw      = MemRead | MemWrite;
        is_word = LLSC | (~MemHalf & ~MemByte);
        aligned = 1'b1;
        be_n    = 4'b1111;
        wdata_n = ReadData2;
        if (is_word) begin
            aligned = (ALUResult[1:0] == 2'b00);
        end else if (MemHalf) begin
            aligned = ~ALUResult[0];
            be_n    = 4'b0011 << ALUResult[1:0];
            wdata_n = {2{ReadData2[15:0]}};
        end else begin
            be_n    = 4'b0001 << ALUResult[1:0];
            wdata_n = {4{ReadData2[7:0]}};
        end
        misaligned = rw & ~Flush & ~aligned;
        // SC without a live link completes at once with result 0
        sc_fail    = MemWrite & LLSC & ~ll_bit;
        access     = rw & ~Flush & aligned & ~sc_fail;
    end

    always_comb begin
        ExcAdEL  = rst_n & misaligned & MemRead;
        ExcAdES  = rst_n & misaligned & ~MemRead;
        BadVAddr = (ExcAdEL | ExcAdES) ? ALUResult : 32'd0;
        MemStall = (access & (state != DONE))
                 | ((state == DRAIN) & rw);
    end

    always_comb begin
        lane_b   = rdata_q[{lo_q, 3'b000} +: 8];
        lane_h   = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_ext = rdata_q;
        if (byte_q) begin
            load_ext = {{24{sext_q & lane_b[7]}}, lane_b};
        end else if (half_q) begin
            load_ext = {{16{sext_q & lane_h[15]}}, lane_h};
        end
        MemReadData = 32'd0;
        if (state == DONE) begin
            if (sc_q) begin
                MemReadData = 32'd1;
            end else if (rd_q) begin
                MemReadData = load_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ll_bit     <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'd0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            rdata_q    <= 32'd0;
            lo_q       <= 2'd0;
            rd_q       <= 1'b0;
            half_q     <= 1'b0;
            byte_q     <= 1'b0;
            sext_q     <= 1'b0;
            ll_q       <= 1'b0;
            sc_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        state      <= WAIT;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite;
                        dmem_be    <= be_n;
                        dmem_addr  <= {ALUResult[31:2], 2'b00};
                        dmem_wdata <= wdata_n;
                        lo_q       <= ALUResult[1:0];
                        rd_q       <= MemRead;
                        half_q     <= ~is_word & MemHalf;
                        byte_q     <= ~is_word & ~MemHalf;
                        sext_q     <= MemSignExtend;
                        ll_q       <= MemRead & LLSC;
                        sc_q       <= MemWrite & LLSC;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        rdata_q  <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end else if (Flush) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                end
            endcase

            // flush kills the link even when an LL completes alongside it
            if (Flush) begin
                ll_bit <= 1'b0;
            end else if (state == DONE && ll_q) begin
                ll_bit <= 1'b1;
            end else if (state == DONE && sc_q) begin
                ll_bit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses, per-cycle model compare
// and literal expectations on load data, lanes, stalls, LL/SC, flush.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        MemRead, MemWrite, MemHalf, MemByte;
    logic        MemSignExtend, LLSC, Flush;
    logic [31:0] ALUResult, ReadData2, dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, MemReadData, BadVAddr;
    logic        MemStall, ExcAdEL, ExcAdES;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;
    bit m_ll   = 0;

    logic        e_req, e_stall, e_adel, e_ades, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_mrd, e_bad, e_addr, e_wd;

    int          n_stall, n_req;
    logic [31:0] o_mrd, o_bad, o_wd;
    logic [3:0]  o_be;
    logic        o_we, o_es, o_el;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .MemHalf(MemHalf), .MemByte(MemByte),
        .MemSignExtend(MemSignExtend), .LLSC(LLSC),
        .ALUResult(ALUResult), .ReadData2(ReadData2),
        .Flush(Flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack),
        .MemReadData(MemReadData), .MemStall(MemStall),
        .ExcAdEL(ExcAdEL), .ExcAdES(ExcAdES),
        .BadVAddr(BadVAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [31:0] w,
                                             input logic [1:0] a,
                                             input int sz, input bit sx);
        logic [31:0] v;
        v = w >> (8 * int'(a));
        if (sz == 1) begin
            v = v & 32'h0000_00FF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'h0000_FFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", 32'(dmem_req), 32'(e_req));
            chk("stall", 32'(MemStall), 32'(e_stall));
            chk("rdata", MemReadData, e_mrd);
            chk("adel", 32'(ExcAdEL), 32'(e_adel));
            chk("ades", 32'(ExcAdES), 32'(e_ades));
            chk("badva", BadVAddr, e_bad);
            if (e_req) begin
                chk("be", 32'(dmem_be), 32'(e_be));
                chk("addr", dmem_addr, e_addr);
                chk("we", 32'(dmem_we), 32'(e_we));
                if (e_we) chk("wdata", dmem_wdata, e_wd);
            end
        end
    end

    task automatic idle();
        MemRead = 0; MemWrite = 0; MemHalf = 0; MemByte = 0;
        MemSignExtend = 0; LLSC = 0; Flush = 0;
        ALUResult = 0; ReadData2 = 0;
        dmem_ack = 0; dmem_rdata = 0;
        e_req = 0; e_stall = 0; e_mrd = 0;
        e_adel = 0; e_ades = 0; e_bad = 0;
    endtask

    task automatic step(input bit res);
        @(negedge clk);
        if (MemStall) n_stall++;
        if (dmem_req) begin
            n_req++;
            o_be = dmem_be;
            o_wd = dmem_wdata;
            o_we = dmem_we;
        end
        if (res) begin
            o_mrd = MemReadData;
            o_es  = ExcAdES;
            o_el  = ExcAdEL;
            o_bad = BadVAddr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic prep(input bit rd, wr, hf, by, sx, ll,
                        input logic [31:0] a, wd, output int sz);
        MemRead = rd; MemWrite = wr; MemHalf = hf; MemByte = by;
        MemSignExtend = sx; LLSC = ll; Flush = 0;
        ALUResult = a; ReadData2 = wd;
        sz = (ll || (!hf && !by)) ? 4 : (hf ? 2 : 1);
        e_addr = a & 32'hFFFF_FFFC;
        e_be = 4'(((1 << sz) - 1) << a[1:0]);
        e_we = wr;
        if (sz == 4) e_wd = wd;
        else if (sz == 2) e_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        else e_wd = (wd & 32'hFF) * 32'h0101_0101;
        e_adel = 0; e_ades = 0; e_bad = 0;
    endtask

    // w = WAIT cycles without ack before the ack cycle
    task automatic op(input bit rd, wr, hf, by, sx, ll,
                      input logic [31:0] a, wd, rdat, input int w);
        int sz;
        bit mis;
        n_stall = 0; n_req = 0; o_mrd = 'x;
        o_es = 0; o_el = 0; o_bad = 'x;
        prep(rd, wr, hf, by, sx, ll, a, wd, sz);
        mis = (sz == 4) ? (a[1:0] != 2'b00) : ((sz == 2) ? a[0] : 1'b0);
        dmem_ack = 0; e_mrd = 0; e_req = 0;
        if (mis) begin
            e_adel = rd; e_ades = !rd; e_bad = a; e_stall = 0;
            step(1);
        end else if (wr && ll && !m_ll) begin
            e_stall = 0;
            step(1);
        end else begin
            e_stall = 1; dmem_ack = 1; dmem_rdata = $urandom;
            step(0);
            e_req = 1;
            for (int k = 0; k <= w; k++) begin
                dmem_ack = (k == w);
                dmem_rdata = (k == w) ? rdat : $urandom;
                step(0);
            end
            e_req = 0; e_stall = 0;
            if (wr && ll) e_mrd = 32'd1;
            else if (rd) e_mrd = load_val(rdat, a[1:0], sz, sx);
            else e_mrd = 32'd0;
            dmem_ack = 1; dmem_rdata = $urandom;
            step(1);
            if (ll) m_ll = rd;
        end
        idle();
    endtask

    initial begin
        int sz;
        rst_n = 0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_be", 32'(dmem_be), 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_mrd", MemReadData, 0);
        chk("rst_bad", BadVAddr, 0);
        chk("rst_stall", 32'(MemStall), 0);
        rst_n = 1;
        chk_en = 1;
        @(posedge clk);
        #1;

        op(1, 0, 0, 0, 0, 0, 32'h100, 0, 32'hDEAD_BEEF, 0);
        chk("lw_stall", n_stall, 2);
        chk("lw_data", o_mrd, 32'hDEAD_BEEF);
        chk("lw_be", 32'(o_be), 32'hF);

        op(1, 0, 0, 1, 1, 0, 32'h103, 0, 32'h80FF_FFFF, 1);
        chk("lb_data", o_mrd, 32'hFFFF_FF80);
        op(1, 0, 0, 1, 0, 0, 32'h103, 0, 32'h80FF_FFFF, 0);
        chk("lbu_data", o_mrd, 32'h0000_0080);
        op(1, 0, 1, 0, 1, 0, 32'h102, 0, 32'h8001_7FFF, 0);
        chk("lh_data", o_mrd, 32'hFFFF_8001);
        op(1, 0, 1, 0, 0, 0, 32'h100, 0, 32'h1234_F00D, 2);
        chk("lhu_data", o_mrd, 32'h0000_F00D);

        op(0, 1, 1, 0, 0, 0, 32'h201, 32'h1234, 0, 0);
        chk("sh_ades", 32'(o_es), 1);
        chk("sh_bad", o_bad, 32'h201);
        chk("sh_nreq", n_req, 0);
        chk("sh_stall", n_stall, 0);
        op(1, 0, 0, 0, 0, 0, 32'h102, 0, 0, 0);
        chk("lw_adel", 32'(o_el), 1);
        chk("lw_bad", o_bad, 32'h102);

        op(0, 1, 0, 1, 0, 0, 32'h102, 32'hAB, 0, 2);
        chk("sb_be", 32'(o_be), 32'h4);
        chk("sb_wd", o_wd, 32'hABAB_ABAB);
        chk("sb_we", 32'(o_we), 1);
        chk("sb_stall", n_stall, 4);
        op(0, 1, 1, 0, 0, 0, 32'h202, 32'h1234, 0, 0);
        chk("sh_be", 32'(o_be), 32'hC);
        chk("sh_wd", o_wd, 32'h1234_1234);

        op(1, 0, 0, 0, 0, 1, 32'h40, 0, 32'h5555_AAAA, 0);
        chk("ll_data", o_mrd, 32'h5555_AAAA);
        op(0, 1, 0, 0, 0, 1, 32'h40, 32'hCAFE_0001, 0, 1);
        chk("sc_ok", o_mrd, 32'd1);
        chk("sc_nreq", n_req, 2);
        chk("sc_wd", o_wd, 32'hCAFE_0001);
        op(0, 1, 0, 0, 0, 1, 32'h40, 32'h1, 0, 0);
        chk("sc_again", o_mrd, 32'd0);
        chk("sc_again_nreq", n_req, 0);

        op(1, 0, 0, 0, 0, 1, 32'h40, 0, 32'h1, 0);
        Flush = 1;
        step(0);
        m_ll = 0;
        idle();
        op(0, 1, 0, 0, 0, 1, 32'h40, 32'h2, 0, 0);
        chk("scf_data", o_mrd, 32'd0);
        chk("scf_nreq", n_req, 0);
        chk("scf_stall", n_stall, 0);

        op(1, 0, 0, 0, 0, 1, 32'h40, 0, 32'h3, 0);
        n_req = 0;
        prep(1, 0, 0, 0, 0, 1, 32'h40, 0, sz);
        dmem_ack = 0; e_req = 0; e_stall = 1; e_mrd = 0;
        step(0);
        Flush = 1; e_req = 1; e_stall = 0;
        step(0);
        m_ll = 0;
        MemRead = 0; LLSC = 0; Flush = 0;
        step(0);
        MemRead = 1; ALUResult = 32'h80; e_stall = 1;
        dmem_ack = 1; dmem_rdata = $urandom;
        step(0);
        chk("drain_nreq", n_req, 3);
        idle();
        op(1, 0, 0, 0, 0, 0, 32'h80, 0, 32'h0BAD_F00D, 0);
        chk("post_drain", o_mrd, 32'h0BAD_F00D);
        op(0, 1, 0, 0, 0, 1, 32'h40, 32'h4, 0, 0);
        chk("drain_sc", o_mrd, 32'd0);
        chk("drain_sc_nreq", n_req, 0);

        op(1, 0, 0, 0, 0, 1, 32'h40, 0, 32'h5, 0);
        prep(1, 0, 0, 0, 0, 0, 32'h300, 0, sz);
        dmem_ack = 0; e_req = 0; e_stall = 1; e_mrd = 0;
        step(0);
        e_req = 1;
        step(0);
        chk_en = 0;
        rst_n = 0;
        #1;
        chk("rst_wait_req", 32'(dmem_req), 0);
        chk("rst_wait_be", 32'(dmem_be), 0);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1;
        m_ll = 0;
        chk_en = 1;
        repeat (3) step(0);
        op(0, 1, 0, 0, 0, 1, 32'h40, 32'h6, 0, 0);
        chk("rst_sc", o_mrd, 32'd0);
        chk("rst_sc_nreq", n_req, 0);
        op(1, 0, 0, 0, 0, 0, 32'h300, 0, 32'h7777_0000, 0);
        chk("rst_lw", o_mrd, 32'h7777_0000);
        chk("rst_lw_stall", n_stall, 2);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
